// File: rtl/core_seq_pkg.sv
// Shared definitions for the core_seq tile sequencer: FSM state codes, inst bit
// positions and the inst field record with its packing helpers.
package core_seq_pkg;

  localparam int INST_W = 34;
  localparam int A_W    = 11;

  localparam int ACC        = 33;
  localparam int CEN_PMEM   = 32;
  localparam int WEN_PMEM   = 31;
  localparam int A_PMEM_LSB = 20;
  localparam int CEN_XMEM   = 19;
  localparam int WEN_XMEM   = 18;
  localparam int A_XMEM_LSB = 7;
  localparam int OFIFO_RD   = 6;
  localparam int IFIFO_WR   = 5;
  localparam int IFIFO_RD   = 4;
  localparam int L0_RD      = 3;
  localparam int L0_WR      = 2;
  localparam int EXECUTE    = 1;
  localparam int LOAD       = 0;

  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WLD   = 3'd1;
  localparam state_t S_WLOAD = 3'd2;
  localparam state_t S_ALD   = 3'd3;
  localparam state_t S_EXEC  = 3'd4;
  localparam state_t S_WB    = 3'd5;
  localparam state_t S_FIN   = 3'd6;

  typedef struct packed {
    logic           acc;
    logic           cen_p;
    logic           wen_p;
    logic [A_W-1:0] a_p;
    logic           cen_x;
    logic           wen_x;
    logic [A_W-1:0] a_x;
    logic           ofifo_rd;
    logic           ififo_wr;
    logic           ififo_rd;
    logic           l0_rd;
    logic           l0_wr;
    logic           execute;
    logic           load;
  } inst_f_t;

  function automatic inst_f_t idle_fields();
    inst_f_t f;
    f       = '0;
    f.cen_p = 1'b1;
    f.wen_p = 1'b1;
    f.cen_x = 1'b1;
    f.wen_x = 1'b1;
    return f;
  endfunction

  function automatic logic [INST_W-1:0] pack_inst(inst_f_t f);
    logic [INST_W-1:0] v;
    v                    = '0;
    v[ACC]               = f.acc;
    v[CEN_PMEM]          = f.cen_p;
    v[WEN_PMEM]          = f.wen_p;
    v[A_PMEM_LSB +: A_W] = f.a_p;
    v[CEN_XMEM]          = f.cen_x;
    v[WEN_XMEM]          = f.wen_x;
    v[A_XMEM_LSB +: A_W] = f.a_x;
    v[OFIFO_RD]          = f.ofifo_rd;
    v[IFIFO_WR]          = f.ififo_wr;
    v[IFIFO_RD]          = f.ififo_rd;
    v[L0_RD]             = f.l0_rd;
    v[L0_WR]             = f.l0_wr;
    v[EXECUTE]           = f.execute;
    v[LOAD]              = f.load;
    return v;
  endfunction

endpackage

// File: rtl/seq_xmem_streamer.sv
// Streams n_rows xmem reads from a base address; wr_en follows each read by one
// cycle to cover the xmem read latency. fin marks the trailing (n_rows+1)th cycle.
module seq_xmem_streamer #(
  parameter int addr_w = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [addr_w-1:0] base,
  input  logic [addr_w-1:0] n_rows,
  output logic              rd_en,
  output logic [addr_w-1:0] rd_addr,
  output logic              wr_en,
  output logic              fin
);

  logic              active;
  logic              rd_d;
  logic [addr_w-1:0] rem;
  logic [addr_w-1:0] addr;

  assign rd_en   = active && (rem != '0);
  assign rd_addr = addr;
  assign wr_en   = rd_d;
  assign fin     = active && (rem == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      rd_d   <= 1'b0;
      rem    <= '0;
      addr   <= '0;
    end else if (load) begin
      active <= 1'b1;
      rd_d   <= 1'b0;
      rem    <= n_rows;
      addr   <= base;
    end else if (active) begin
      rd_d <= rd_en;
      if (rem != '0) begin
        rem  <= rem - 1'b1;
        addr <= addr + 1'b1;
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_seq.sv
// Tile instruction sequencer for the compute core. Define SEQ_PERF_CNT_EN to add
// the perf_cycles / perf_wb_stall counters.
//
// state   | meaning
// IDLE    | waiting for start, inst = IDLE_INST
// WLD     | weight rows xmem -> L0 (col reads, l0_wr one cycle behind)
// WLOAD   | L0 -> MAC array weight load, then array drain
// ALD     | activation rows xmem -> L0 (nij reads)
// EXEC    | stream activations and execute, then drain
// WB      | output FIFO -> PSUM SRAM, one pmem write per ofifo_rd
// FIN     | done pulse, back to IDLE
module core_seq
  import core_seq_pkg::*;
#(
  parameter int col    = 8,
  parameter int row    = 8,
  parameter int addr_w = 11,
  parameter int kij_w  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [kij_w-1:0]  cfg_nkij,
  input  logic [addr_w-1:0] cfg_nij,
  input  logic [addr_w-1:0] cfg_w_base,
  input  logic [addr_w-1:0] cfg_act_base,
  input  logic [addr_w-1:0] cfg_psum_base,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              busy,
  output logic              done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_wb_stall
`endif
);

  localparam int TMR_W = addr_w + 1;
  localparam int DRAIN = row + col;

  state_t            state, nxt;
  inst_f_t           f;
  logic [kij_w-1:0]  k, k_inc, nkij_r;
  logic [addr_w-1:0] nij_r, act_r, w_run, p_run, rd_cnt, wr_cnt;
  logic              rd_pend;
  logic [TMR_W-1:0]  tmr;

  logic              str_load, str_rd, str_wr, str_fin;
  logic [addr_w-1:0] str_base, str_n, str_addr;

  assign k_inc = k + 1'b1;

  seq_xmem_streamer #(.addr_w(addr_w)) u_streamer (
    .clk     (clk),
    .reset   (reset),
    .load    (str_load),
    .base    (str_base),
    .n_rows  (str_n),
    .rd_en   (str_rd),
    .rd_addr (str_addr),
    .wr_en   (str_wr),
    .fin     (str_fin)
  );

  always_comb begin
    nxt = state;
    f   = idle_fields();
    case (state)
      S_IDLE: if (start) nxt = (cfg_nkij == '0 || cfg_nij == '0) ? S_FIN : S_WLD;
      S_WLD, S_ALD: begin
        if (str_rd) begin
          f.cen_x = 1'b0;
          f.a_x   = A_W'(str_addr);
        end
        f.l0_wr = str_wr;
        if (str_fin) nxt = (state == S_WLD) ? S_WLOAD : S_EXEC;
      end
      S_WLOAD: begin
        f.l0_rd = (tmr >= TMR_W'(DRAIN));
        f.load  = (tmr >= TMR_W'(DRAIN));
        if (tmr == '0) nxt = S_ALD;
      end
      S_EXEC: begin
        f.execute = 1'b1;
        f.acc     = (k != '0);
        f.l0_rd   = (tmr >= TMR_W'(DRAIN));
        if (tmr == '0) nxt = S_WB;
      end
      S_WB: begin
        f.ofifo_rd = ofifo_valid && (rd_cnt < nij_r);
        if (rd_pend) begin
          f.cen_p = 1'b0;
          f.wen_p = 1'b0;
          f.a_p   = A_W'(p_run + wr_cnt);
        end
        if (wr_cnt == nij_r) nxt = (k_inc == nkij_r) ? S_FIN : S_WLD;
      end
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    str_load = (nxt == S_WLD || nxt == S_ALD) && (nxt != state);
    // Entering WLD from WB must already see the next kij's weight base.
    if (state == S_IDLE)    str_base = cfg_w_base;
    else if (state == S_WB) str_base = w_run + addr_w'(col);
    else                    str_base = act_r;
    str_n = (nxt == S_WLD) ? addr_w'(col) : nij_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      inst    <= IDLE_INST;
      busy    <= 1'b0;
      done    <= 1'b0;
      k       <= '0;
      nkij_r  <= '0;
      nij_r   <= '0;
      act_r   <= '0;
      w_run   <= '0;
      p_run   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      rd_pend <= 1'b0;
      tmr     <= '0;
    end else begin
      state <= nxt;
      inst  <= pack_inst(f);
      done  <= (state == S_FIN);
      if (state == S_IDLE && start) begin
        nkij_r <= cfg_nkij;
        nij_r  <= cfg_nij;
        act_r  <= cfg_act_base;
        w_run  <= cfg_w_base;
        p_run  <= cfg_psum_base;
        k      <= '0;
        busy   <= 1'b1;
      end
      if (state == S_FIN) busy <= 1'b0;

      if (nxt != state && nxt == S_WLOAD)     tmr <= TMR_W'(2 * col + row - 1);
      else if (nxt != state && nxt == S_EXEC) tmr <= TMR_W'(nij_r) + TMR_W'(DRAIN - 1);
      else if (tmr != '0)                     tmr <= tmr - 1'b1;

      if (nxt != state && nxt == S_WB) begin
        rd_cnt  <= '0;
        wr_cnt  <= '0;
        rd_pend <= 1'b0;
      end else if (state == S_WB) begin
        rd_pend <= f.ofifo_rd;
        if (f.ofifo_rd) rd_cnt <= rd_cnt + 1'b1;
        if (rd_pend)    wr_cnt <= wr_cnt + 1'b1;
        if (nxt != S_WB) begin
          k     <= k_inc;
          w_run <= w_run + addr_w'(col);
          p_run <= p_run + nij_r;
        end
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles   <= '0;
      perf_wb_stall <= '0;
    end else if (state == S_IDLE && start) begin
      perf_cycles   <= '0;
      perf_wb_stall <= '0;
    end else begin
      if (busy) perf_cycles <= perf_cycles + 1'b1;
      if (state == S_WB && !ofifo_valid && rd_cnt < nij_r) perf_wb_stall <= perf_wb_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: table of tile configurations with hand-computed
// instruction-stream totals, plus sequences for restart, zero-size and reset.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_nkij = '0;
  logic [10:0] cfg_nij = '0, cfg_w_base = '0, cfg_act_base = '0, cfg_psum_base = '0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        busy, done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_wb_stall;
`endif

  localparam logic [33:0] IDLE_EXP = 34'h1_800C_0000;

  always #5 clk = ~clk;

  core_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_nkij      (cfg_nkij),
    .cfg_nij       (cfg_nij),
    .cfg_w_base    (cfg_w_base),
    .cfg_act_base  (cfg_act_base),
    .cfg_psum_base (cfg_psum_base),
    .ofifo_valid   (ofifo_valid),
    .inst          (inst),
    .busy          (busy),
    .done          (done)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_wb_stall (perf_wb_stall)
`endif
  );

  typedef struct {
    int     nkij, nij, w_base, act_base, psum_base, stall;
    int     x_rd;
    longint x_sum;
    int     n_load, n_exec, n_acc, n_pwr;
    longint p_sum;
    int     p_first, p_last, cyc;
  } vec_t;

  vec_t vecs[4];
  int   tests = 0;
  int   fails = 0;

  int     n_xrd, n_load, n_exec, n_acc, n_ord, n_pwr, n_done, proto_err, p_first, p_last;
  longint xsum, psum;
  logic   prev_xrd, prev_ord;

  always @(negedge clk) begin : mon
    logic xrd, ord, pwr;
    if (!reset) begin
      xrd = ~inst[19] & inst[18];
      ord = inst[6];
      pwr = ~inst[32] & ~inst[31];
      if (xrd) begin n_xrd++; xsum += longint'(inst[17:7]); end
      if (inst[2] != prev_xrd) proto_err++;
      if (inst[0]) n_load++;
      if (inst[1]) n_exec++;
      if (inst[33]) n_acc++;
      if (ord) begin n_ord++; if (!ofifo_valid) proto_err++; end
      if (pwr != prev_ord) proto_err++;
      if (pwr) begin
        if (n_pwr == 0) p_first = int'(inst[30:20]);
        p_last = int'(inst[30:20]);
        psum += longint'(inst[30:20]);
        n_pwr++;
      end
      if (inst[5] | inst[4]) proto_err++;
      if (!busy && inst != IDLE_EXP) proto_err++;
      if (done) n_done++;
      prev_xrd = xrd;
      prev_ord = ord;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_xrd = 0; n_load = 0; n_exec = 0; n_acc = 0; n_ord = 0; n_pwr = 0;
    n_done = 0; proto_err = 0; p_first = -1; p_last = -1;
    xsum = 0; psum = 0; prev_xrd = 1'b0; prev_ord = 1'b0;
  endtask

  task automatic set_cfg(input int nkij, input int nij, input int wb, input int ab, input int pb);
    cfg_nkij      = 4'(nkij);
    cfg_nij       = 11'(nij);
    cfg_w_base    = 11'(wb);
    cfg_act_base  = 11'(ab);
    cfg_psum_base = 11'(pb);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    if (cyc >= 3000) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic run_tile(input vec_t v, input string nm);
    clear_mon();
    set_cfg(v.nkij, v.nij, v.w_base, v.act_base, v.psum_base);
    ofifo_valid = (v.stall == 0);
    pulse_start();
    if (v.stall != 0) begin
      int  cyc = 0;
      bit  seen = 0;
      while (!(seen && !inst[1]) && cyc < 2000) begin
        @(negedge clk);
        if (inst[1]) seen = 1;
        cyc++;
      end
      if (cyc >= 2000) chk({nm, "_exec_timeout"}, 0, 1);
      repeat (v.stall - 1) @(negedge clk);
      #1 ofifo_valid = 1'b1;
    end
    wait_done(nm);
    repeat (3) @(negedge clk);
    chk({nm, "_xrd"},    n_xrd,   v.x_rd);
    chk({nm, "_xsum"},   xsum,    v.x_sum);
    chk({nm, "_load"},   n_load,  v.n_load);
    chk({nm, "_exec"},   n_exec,  v.n_exec);
    chk({nm, "_acc"},    n_acc,   v.n_acc);
    chk({nm, "_ofifo"},  n_ord,   v.n_pwr);
    chk({nm, "_pwr"},    n_pwr,   v.n_pwr);
    chk({nm, "_psum"},   psum,    v.p_sum);
    chk({nm, "_pfirst"}, p_first, v.p_first);
    chk({nm, "_plast"},  p_last,  v.p_last);
    chk({nm, "_done"},   n_done,  1);
    chk({nm, "_proto"},  proto_err, 0);
`ifdef SEQ_PERF_CNT_EN
    chk({nm, "_perf_cyc"},   perf_cycles,   v.cyc);
    chk({nm, "_perf_stall"}, perf_wb_stall, v.stall);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          nkij nij wb    ab    pb    stall xrd xsum   load exec acc pwr psum  first last cyc
    vecs[0] = '{1,   4,  0,    16,   100,  0,    12, 98,    8,   20,  0,  4,  406,  100,  103, 65};
    vecs[1] = '{3,   2,  0,    40,   0,    0,    30, 519,   24,  54,  36, 6,  15,   0,    5,   175};
    vecs[2] = '{2,   3,  2044, 2046, 2046, 0,    22, 16434, 16,  38,  19, 6,  4099, 2046, 3,   123};
    vecs[3] = '{1,   4,  8,    32,   200,  10,   12, 226,   8,   20,  0,  4,  806,  200,  203, 75};

    clear_mon();
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_inst", inst, IDLE_EXP);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    for (int i = 0; i < 4; i++) run_tile(vecs[i], $sformatf("v%0d", i));

    // Second start while busy, with changed config, must not disturb the tile.
    clear_mon();
    ofifo_valid = 1'b1;
    set_cfg(1, 4, 0, 16, 100);
    pulse_start();
    repeat (5) @(negedge clk);
    set_cfg(2, 3, 64, 80, 300);
    pulse_start();
    wait_done("restart");
    repeat (3) @(negedge clk);
    chk("restart_done", n_done, 1);
    chk("restart_pwr",  n_pwr, 4);
    chk("restart_psum", psum, 406);
    chk("restart_xsum", xsum, 98);

    clear_mon();
    set_cfg(2, 0, 0, 0, 0);
    pulse_start();
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", done, 0);
    chk("zero_inst_c1", inst, IDLE_EXP);
    @(negedge clk);
    chk("zero_done_c2", done, 1);
    chk("zero_busy_c2", busy, 0);
    @(negedge clk);
    chk("zero_done_c3", done, 0);
    chk("zero_xrd",   n_xrd, 0);
    chk("zero_proto", proto_err, 0);

    // Reset in the middle of EXEC aborts the tile.
    clear_mon();
    set_cfg(3, 2, 0, 40, 0);
    pulse_start();
    begin
      int cyc = 0;
      while (!inst[1] && cyc < 2000) begin @(negedge clk); cyc++; end
      if (cyc >= 2000) chk("mid_exec_timeout", 0, 1);
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_inst", inst, IDLE_EXP);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk); #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", n_done + int'(done), 0);
    run_tile(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
